// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC sequencing, IF/ID register, one-entry skid buffer and redirect handling.
// Optional macro FETCH_TIMEOUT_EN adds a sticky fetch_err flag for requests left unacknowledged too long.
module fetch_unit (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [25:0] jump_target,
    output logic [31:0] instr_out,
    output logic [5:0]  opcode,
    output logic [31:0] pc4_out,
    output logic        valid_out,
    output logic        fetch_err
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DISCARD} state_t;

    state_t      state, state_next;
    logic [31:0] pc, pc_next, pc_plus4;
    logic [31:0] discard_addr;
    logic [31:0] skid_instr, skid_pc4;
    logic        skid_valid;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        ifid_from_mem, ifid_from_skid, ifid_bubble;
    logic        skid_load, skid_clear, discard_load;

    assign pc_plus4        = pc + 32'd4;
    assign opcode          = instr_out[31:26];
    assign redirect        = valid_out && !stall && (jump || branch_taken);
    assign redirect_target = jump ? {pc4_out[31:28], jump_target, 2'b00} : branch_target;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // A redirect that lands while a request is still unacknowledged must let that request
    // complete at its original address before fetching from the target.
    always_comb begin
        state_next     = state;
        pc_next        = pc;
        imem_req       = 1'b0;
        imem_addr      = pc;
        ifid_from_mem  = 1'b0;
        ifid_from_skid = 1'b0;
        ifid_bubble    = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        discard_load   = 1'b0;
        case (state)
            IDLE: state_next = FETCH;
            FETCH: begin
                imem_req = 1'b1;
                if (redirect) begin
                    pc_next     = redirect_target;
                    ifid_bubble = 1'b1;
                    skid_clear  = 1'b1;
                    if (!imem_ack) begin
                        state_next   = DISCARD;
                        discard_load = 1'b1;
                    end
                end else if (imem_ack) begin
                    pc_next = pc_plus4;
                    if (stall) begin
                        skid_load  = 1'b1;
                        state_next = HOLD;
                    end else begin
                        ifid_from_mem = 1'b1;
                    end
                end else if (!stall) begin
                    ifid_bubble = 1'b1;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_next     = redirect_target;
                    ifid_bubble = 1'b1;
                    skid_clear  = 1'b1;
                    state_next  = FETCH;
                end else if (!stall) begin
                    ifid_from_skid = 1'b1;
                    skid_clear     = 1'b1;
                    state_next     = FETCH;
                end
            end
            DISCARD: begin
                imem_req  = 1'b1;
                imem_addr = discard_addr;
                if (imem_ack) state_next = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc           <= 32'h0;
            instr_out    <= 32'h0;
            pc4_out      <= 32'h0;
            valid_out    <= 1'b0;
            skid_instr   <= 32'h0;
            skid_pc4     <= 32'h0;
            skid_valid   <= 1'b0;
            discard_addr <= 32'h0;
        end else begin
            pc <= pc_next;
            if (ifid_from_mem) begin
                instr_out <= imem_rdata;
                pc4_out   <= pc_plus4;
                valid_out <= 1'b1;
            end else if (ifid_from_skid) begin
                instr_out <= skid_instr;
                pc4_out   <= skid_pc4;
                valid_out <= skid_valid;
            end else if (ifid_bubble) begin
                valid_out <= 1'b0;
            end
            if (skid_load) begin
                skid_instr <= imem_rdata;
                skid_pc4   <= pc_plus4;
                skid_valid <= 1'b1;
            end else if (skid_clear) begin
                skid_valid <= 1'b0;
            end
            if (discard_load) discard_addr <= pc;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    logic [3:0] timeout_count;

    // The counter saturates at 15; fetch_err is set on the edge the count first reaches 15.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout_count <= 4'd0;
            fetch_err     <= 1'b0;
        end else if (imem_ack) begin
            timeout_count <= 4'd0;
        end else if (imem_req) begin
            if (timeout_count != 4'd15) timeout_count <= timeout_count + 4'd1;
            if (timeout_count == 4'd14) fetch_err <= 1'b1;
        end
    end
`else
    assign fetch_err = 1'b0;
`endif

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst  in  1  asynchronous, active-high reset.
REQ-003 imem_req  out  1  instruction-memory request.
REQ-004 imem_addr  out  32  word address of request; PC value.
REQ-005 imem_ack  in  1  memory accepts request; imem_rdata valid same cycle.
REQ-006 imem_rdata  in  32  fetched instruction.
REQ-007 stall  in  1  downstream hazard; freeze IF/ID register and PC.
REQ-008 branch_taken  in  1  taken conditional branch (beq/ben class) for current instr_out.
REQ-009 branch_target  in  32  full branch destination.
REQ-010 jump  in  1  j-class redirect for current instr_out.
REQ-011 jump_target  in  26  jump index field.
REQ-012 instr_out  out  32  IF/ID instruction register.
REQ-013 opcode  out  6  instr_out[31:26], feeds decode control.
REQ-014 pc4_out  out  32  IF/ID PC+4 of instr_out.
REQ-015 valid_out  out  1  instr_out holds a live instruction.
REQ-016 fetch_err  out  1  sticky fetch-timeout flag (see Configuration).

Function
REQ-017 States SHALL be IDLE, FETCH, HOLD, DISCARD; reset enters IDLE; IDLE -> FETCH unconditionally next cycle.
REQ-018 FETCH: imem_req=1, imem_addr=PC; once raised, req and addr SHALL stay stable until imem_ack.
REQ-019 Ack in FETCH with stall=0: instr_out<=imem_rdata, pc4_out<=PC+4, valid_out<=1, PC<=PC+4, stay FETCH (next request issued immediately, throughput 1 instr/cycle).
REQ-020 Ack in FETCH with stall=1: data and PC+4 captured into one-entry skid buffer, PC<=PC+4, IF/ID unchanged, go HOLD.
REQ-021 No ack in FETCH: IF/ID unchanged if stall=1, else valid_out<=0 (bubble).
REQ-022 HOLD: imem_req=0; when stall=0, skid -> IF/ID, valid_out<=1, go FETCH.
REQ-023 Redirect SHALL be accepted only when valid_out=1 and stall=0; jump has priority over branch_taken.
REQ-024 Jump target = {pc4_out[31:28], jump_target, 2'b00}; branch target = branch_target.
REQ-025 On redirect: PC<=target, valid_out<=0, skid buffer invalidated; if request outstanding and imem_ack=0, go DISCARD, else go FETCH (same-cycle ack data dropped).
REQ-026 DISCARD: hold old req/addr until imem_ack, drop data, then FETCH at target.
REQ-027 PC+4 SHALL wrap modulo 2^32 (0xFFFFFFFC -> 0x00000000).
REQ-028 opcode SHALL be combinational from instr_out.

Reset
REQ-029 rst=1 SHALL immediately force: state IDLE, PC=0x00000000, imem_req=0, instr_out=0, pc4_out=0, valid_out=0, skid empty, fetch_err=0, timeout counter 0.
REQ-030 Reset mid-request abandons the request; after release first fetch SHALL be address 0x00000000.

Configuration
REQ-031 Macro FETCH_TIMEOUT_EN defined: 4-bit counter increments each cycle imem_req=1 and imem_ack=0, clears on ack; reaching 15 sets fetch_err sticky until rst; fetching continues.
REQ-032 Macro undefined: no counter, fetch_err tied 0.

Verification
REQ-033 Release rst, ack every cycle, rdata=0x8C010004 -> imem_addr 0x0,0x4,0x8 on consecutive cycles; opcode=6'b100011, pc4_out=0x4 after first ack.
REQ-034 Ack at PC=0x8 while stall=1 for 3 cycles -> IF/ID unchanged, req low in HOLD; stall drop -> instr from 0x8 appears, next addr 0xC.
REQ-035 valid_out=1, pc4_out=0x10000010, jump=1, jump_target=0x0000040 -> next imem_addr 0x10000100, valid_out 0 one cycle.
REQ-036 branch_taken=1, branch_target=0x40 with outstanding unacked request at 0x14 -> DISCARD; ack returns, data dropped, then addr 0x40.
REQ-037 FETCH_TIMEOUT_EN defined, ack withheld 15 cycles -> fetch_err=1, remains 1 after ack until rst; undefined -> stays 0.
REQ-038 PC=0xFFFFFFFC acked -> pc4_out=0x00000000, next imem_addr 0x00000000.
